max3421_spi_responder: RTL and testbench

- Synthesizable SPI peripheral that answers the MAX3421 command protocol: command byte, then data bytes.
- Holds a 32 x 8 register file and serves as the far-end responder for our SPI master blocks in loopback and bring-up builds.
- Runs on its own fast system clock and oversamples SCLK, nSS and MOSI.
- The rest of the design can inspect and update registers through a host port, and sees every SPI write as a strobe.

---
 rtl/max3421_spi_responder.sv | 165 ++++++++++++++++
 tb/tb_max3421_spi_responder.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/max3421_spi_responder.sv
// MAX3421-style SPI responder with a 32x8 register file and a host port. SPI inputs pass through
// SYNC_STAGES flops plus one edge flop. The master paces itself and nothing stalls it; host access has 1-cycle read latency.
module max3421_spi_responder #(
   parameter int          SYNC_STAGES = 2,
   parameter logic [31:0] RO_MASK     = 32'h0000_0000
) (
   input  logic       clk_in,
   input  logic       rst_in,
   input  logic       sclk_in,
   input  logic       n_ss_in,
   input  logic       mosi_in,
   output logic       miso_out,
   output logic       miso_oe_out,
   input  logic [7:0] status_in,
   output logic       wr_valid_out,
   output logic [4:0] wr_addr_out,
   output logic [7:0] wr_data_out,
   input  logic [4:0] host_addr_in,
   input  logic       host_we_in,
   input  logic [7:0] host_wdata_in,
   output logic [7:0] host_rdata_out,
   output logic       busy_out
);

   typedef enum logic [1:0] {IDLE, CMD, DATA} state_t;

   localparam logic [2:0] FILL = 3'(SYNC_STAGES + 1);

   logic [SYNC_STAGES-1:0] sclk_sync_q, ss_sync_q, mosi_sync_q;
   logic                   sclk_prev_q, ss_prev_q;
   logic [2:0]             fill_q;
   logic                   armed_q;

   state_t     state_q;
   logic [6:0] rx_sr_q;
   logic [7:0] tx_sr_q;
   logic [2:0] bit_cnt_q;
   logic [4:0] addr_q;
   logic       dir_q;
   logic       load_pending_q;
   logic       oe_q, busy_q;
   logic       wr_valid_q;
   logic [4:0] wr_addr_q;
   logic [7:0] wr_data_q;
   logic [7:0] host_rdata_q;
   logic [7:0] regs_q [32];

   logic sclk_s, ss_s, mosi_s;
   logic sclk_rise, sclk_fall, ss_fall, ss_rise;
   logic [7:0] rx_d;

   assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
   assign ss_s      = ss_sync_q[SYNC_STAGES-1];
   assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
   assign sclk_rise = sclk_s & ~sclk_prev_q;
   assign sclk_fall = ~sclk_s & sclk_prev_q;
   // Falls are ignored until nSS has been seen high once the chain holds real samples after reset.
   assign ss_fall   = armed_q & ss_prev_q & ~ss_s;
   assign ss_rise   = ss_s & ~ss_prev_q;
   assign rx_d      = {rx_sr_q, mosi_s};

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         sclk_sync_q <= '0;
         ss_sync_q   <= '1;
         mosi_sync_q <= '0;
         sclk_prev_q <= 1'b0;
         ss_prev_q   <= 1'b1;
         fill_q      <= '0;
         armed_q     <= 1'b0;
      end else begin
         sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk_in};
         ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], n_ss_in};
         mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi_in};
         sclk_prev_q <= sclk_s;
         ss_prev_q   <= ss_s;
         if (fill_q != FILL)
            fill_q <= fill_q + 3'd1;
         if (fill_q == FILL && ss_s && ss_prev_q)
            armed_q <= 1'b1;
      end
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state_q        <= IDLE;
         rx_sr_q        <= '0;
         tx_sr_q        <= '0;
         bit_cnt_q      <= '0;
         addr_q         <= '0;
         dir_q          <= 1'b0;
         load_pending_q <= 1'b0;
         oe_q           <= 1'b0;
         busy_q         <= 1'b0;
         wr_valid_q     <= 1'b0;
         wr_addr_q      <= '0;
         wr_data_q      <= '0;
         host_rdata_q   <= '0;
         for (int i = 0; i < 32; i++)
            regs_q[i] <= '0;
      end else begin
         wr_valid_q   <= 1'b0;
         host_rdata_q <= regs_q[host_addr_in];
         // Host write first so a same-cycle SPI commit below overrides it.
         if (host_we_in)
            regs_q[host_addr_in] <= host_wdata_in;

         case (state_q)
            IDLE: begin
               if (ss_fall) begin
                  state_q        <= CMD;
                  tx_sr_q        <= status_in;
                  bit_cnt_q      <= '0;
                  load_pending_q <= 1'b0;
                  oe_q           <= 1'b1;
                  busy_q         <= 1'b1;
               end
            end
            CMD, DATA: begin
               if (sclk_rise) begin
                  rx_sr_q   <= rx_d[6:0];
                  bit_cnt_q <= bit_cnt_q + 3'd1;
                  if (bit_cnt_q == 3'd7) begin
                     load_pending_q <= 1'b1;
                     if (state_q == CMD) begin
                        addr_q  <= rx_d[7:3];
                        dir_q   <= rx_d[1];
                        state_q <= DATA;
                     end else if (dir_q && !RO_MASK[addr_q]) begin
                        regs_q[addr_q] <= rx_d;
                        wr_valid_q     <= 1'b1;
                        wr_addr_q      <= addr_q;
                        wr_data_q      <= rx_d;
                     end
                  end
               end
               if (sclk_fall) begin
                  if (load_pending_q) begin
                     tx_sr_q        <= dir_q ? 8'h00 : regs_q[addr_q];
                     load_pending_q <= 1'b0;
                  end else begin
                     tx_sr_q <= {tx_sr_q[6:0], 1'b0};
                  end
               end
               // Deselect wins over the state move, but a byte completed this cycle is already committed.
               if (ss_rise) begin
                  state_q <= IDLE;
                  oe_q    <= 1'b0;
                  busy_q  <= 1'b0;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign miso_out       = tx_sr_q[7];
   assign miso_oe_out    = oe_q;
   assign busy_out       = busy_q;
   assign wr_valid_out   = wr_valid_q;
   assign wr_addr_out    = wr_addr_q;
   assign wr_data_out    = wr_data_q;
   assign host_rdata_out = host_rdata_q;

endmodule

// File: tb/tb_max3421_spi_responder.sv
// Bench for max3421_spi_responder: table of single-byte transactions plus hand sequences for
// reads, multi-byte writes, RO/abort, host/SPI collision and reset mid-transaction.
`timescale 1ns/1ps
module tb_max3421_spi_responder;

   localparam int H = 6;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       sclk = 1'b0;
   logic       nss = 1'b1;
   logic       mosi = 1'b0;
   logic       miso, miso_oe;
   logic [7:0] status = 8'h00;
   logic       wr_valid;
   logic [4:0] wr_addr;
   logic [7:0] wr_data;
   logic [4:0] host_addr = 5'd0;
   logic       host_we = 1'b0;
   logic [7:0] host_wdata = 8'h00;
   logic [7:0] host_rdata;
   logic       busy;

   int pass_cnt = 0;
   int total_cnt = 0;
   logic [12:0] exp_q [$];

   typedef struct packed {
      logic [7:0] cmd;
      logic [7:0] data;
      logic [7:0] status;
      logic [7:0] exp_rx;
      logic       exp_commit;
      logic [7:0] exp_host;
   } vec_t;

   vec_t vt [7];

   max3421_spi_responder #(.SYNC_STAGES(2), .RO_MASK(32'h0000_0010)) dut (
      .clk_in(clk), .rst_in(rst), .sclk_in(sclk), .n_ss_in(nss), .mosi_in(mosi),
      .miso_out(miso), .miso_oe_out(miso_oe), .status_in(status),
      .wr_valid_out(wr_valid), .wr_addr_out(wr_addr), .wr_data_out(wr_data),
      .host_addr_in(host_addr), .host_we_in(host_we), .host_wdata_in(host_wdata),
      .host_rdata_out(host_rdata), .busy_out(busy)
   );

   always #5 clk = ~clk;

   function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
   endfunction

   // Every strobe must match the oldest expected commit.
   always @(negedge clk) begin
      if (wr_valid === 1'b1) begin
         total_cnt++;
         if (exp_q.size() == 0) begin
            $display("FAIL strobe_unexpected: got addr=%0d data=0x%0h, want none", wr_addr, wr_data);
         end else begin
            logic [12:0] e;
            e = exp_q.pop_front();
            if ({wr_addr, wr_data} === e) pass_cnt++;
            else $display("FAIL strobe: got addr=%0d data=0x%0h, want addr=%0d data=0x%0h",
                          wr_addr, wr_data, e[12:8], e[7:0]);
         end
      end
   end

   initial begin
      #1ms;
      $display("FAIL watchdog: got timeout, want completion");
      $fatal(1, "timeout");
   end

   task automatic spi_start();
      nss = 1'b0;
      repeat (H) @(negedge clk);
      check("busy_hi", busy, 1);
      check("oe_hi", miso_oe, 1);
   endtask

   task automatic spi_stop();
      repeat (H) @(negedge clk);
      nss = 1'b1;
      repeat (2*H) @(negedge clk);
      check("busy_lo", busy, 0);
      check("oe_lo", miso_oe, 0);
   endtask

   task automatic spi_byte(input logic [7:0] tx, input int nbits, input bit collide,
                           output logic [7:0] rx);
      rx = 8'h00;
      for (int i = 7; i >= 8 - nbits; i--) begin
         mosi = tx[i];
         repeat (H) @(negedge clk);
         rx[i] = miso;
         sclk = 1'b1;
         if (collide && i == 0) begin
            repeat (2) @(negedge clk);
            host_addr  = 5'd3;
            host_wdata = 8'hAA;
            host_we    = 1'b1;
            @(negedge clk);
            host_we = 1'b0;
            check("collide_aligned", wr_valid, 1);
            repeat (H-3) @(negedge clk);
         end else begin
            repeat (H) @(negedge clk);
         end
         sclk = 1'b0;
      end
   endtask

   task automatic host_write(input logic [4:0] a, input logic [7:0] d);
      @(negedge clk);
      host_addr = a; host_wdata = d; host_we = 1'b1;
      @(negedge clk);
      host_we = 1'b0;
   endtask

   task automatic host_read(input logic [4:0] a, output logic [7:0] d);
      @(negedge clk);
      host_addr = a;
      @(negedge clk);
      d = host_rdata;
   endtask

   initial begin
      logic [7:0] rx, hv;

      vt[0] = '{8'hA2, 8'h5C, 8'h81, 8'h00, 1'b1, 8'h5C};
      vt[1] = '{8'h27, 8'hFF, 8'h00, 8'h00, 1'b0, 8'h00};
      vt[2] = '{8'hFE, 8'h01, 8'hFF, 8'h00, 1'b1, 8'h01};
      vt[3] = '{8'h03, 8'h80, 8'h5A, 8'h00, 1'b1, 8'h80};
      vt[4] = '{8'hA5, 8'h00, 8'hC3, 8'h5C, 1'b0, 8'h5C};
      vt[5] = '{8'hF8, 8'h00, 8'h12, 8'h01, 1'b0, 8'h01};
      vt[6] = '{8'h00, 8'h00, 8'h3C, 8'h80, 1'b0, 8'h80};

      #1 rst = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_miso", miso, 0);
      check("rst_oe", miso_oe, 0);
      check("rst_wr_valid", wr_valid, 0);
      check("rst_wr_addr", wr_addr, 0);
      check("rst_wr_data", wr_data, 0);
      check("rst_host_rdata", host_rdata, 0);
      check("rst_busy", busy, 0);
      rst = 1'b0;
      repeat (10) @(negedge clk);

      // SCLK toggling while deselected must do nothing.
      spi_byte(8'hA2, 8, 1'b0, rx);
      check("idle_sclk_busy", busy, 0);

      for (int v = 0; v < 7; v++) begin
         status = vt[v].status;
         if (vt[v].exp_commit) exp_q.push_back({vt[v].cmd[7:3], vt[v].data});
         spi_start();
         spi_byte(vt[v].cmd, 8, 1'b0, rx);
         check($sformatf("vec%0d_status", v), rx, vt[v].status);
         spi_byte(vt[v].data, 8, 1'b0, rx);
         check($sformatf("vec%0d_rx", v), rx, vt[v].exp_rx);
         spi_stop();
         host_read(vt[v].cmd[7:3], hv);
         check($sformatf("vec%0d_host", v), hv, vt[v].exp_host);
      end

      // Read with repeated data bytes.
      host_write(5'd7, 8'h3B);
      status = 8'h81;
      spi_start();
      spi_byte(8'h38, 8, 1'b0, rx);
      check("rd_status", rx, 8'h81);
      spi_byte(8'h00, 8, 1'b0, rx);
      check("rd_data0", rx, 8'h3B);
      spi_byte(8'h00, 8, 1'b0, rx);
      check("rd_data1", rx, 8'h3B);
      spi_stop();

      // Multi-byte write to a single register.
      exp_q.push_back({5'd2, 8'h11});
      exp_q.push_back({5'd2, 8'h22});
      exp_q.push_back({5'd2, 8'h33});
      spi_start();
      spi_byte(8'h12, 8, 1'b0, rx);
      spi_byte(8'h11, 8, 1'b0, rx);
      spi_byte(8'h22, 8, 1'b0, rx);
      spi_byte(8'h33, 8, 1'b0, rx);
      spi_stop();
      host_read(5'd2, hv);
      check("multi_final", hv, 8'h33);
      check("multi_drained", exp_q.size(), 0);

      // Partial byte then deselect.
      spi_start();
      spi_byte(8'h4A, 8, 1'b0, rx);
      spi_byte(8'hE7, 5, 1'b0, rx);
      spi_stop();
      host_read(5'd9, hv);
      check("abort_reg9", hv, 8'h00);

      // Host and SPI write reg 3 in the same cycle.
      exp_q.push_back({5'd3, 8'h55});
      spi_start();
      spi_byte(8'h1A, 8, 1'b0, rx);
      spi_byte(8'h55, 8, 1'b1, rx);
      spi_stop();
      host_read(5'd3, hv);
      check("collide_reg3", hv, 8'h55);

      // Reset in the middle of a read data byte, nSS held low.
      spi_start();
      spi_byte(8'h38, 8, 1'b0, rx);
      spi_byte(8'h00, 3, 1'b0, rx);
      @(negedge clk);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      check("rstmid_oe", miso_oe, 0);
      check("rstmid_busy", busy, 0);
      spi_byte(8'hA2, 8, 1'b0, rx);
      spi_byte(8'h77, 8, 1'b0, rx);
      check("rstmid_still_idle", busy, 0);
      host_read(5'd20, hv);
      check("rstmid_reg20", hv, 8'h00);
      host_read(5'd7, hv);
      check("rstmid_reg7", hv, 8'h00);
      nss = 1'b1;
      repeat (2*H) @(negedge clk);

      exp_q.push_back({5'd5, 8'h96});
      status = 8'hE1;
      spi_start();
      spi_byte(8'h2A, 8, 1'b0, rx);
      check("post_wr_status", rx, 8'hE1);
      spi_byte(8'h96, 8, 1'b0, rx);
      spi_stop();
      spi_start();
      spi_byte(8'h28, 8, 1'b0, rx);
      check("post_rd_status", rx, 8'hE1);
      spi_byte(8'h00, 8, 1'b0, rx);
      check("post_rd_data", rx, 8'h96);
      spi_stop();

      repeat (4) @(negedge clk);
      check("strobes_outstanding", exp_q.size(), 0);
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
